// File: rtl/roce_pkg.sv
// -----------------------------------------------------------------------------
// roce_pkg
// Shared RoCE transmit-side definitions: PSN width and type, the window
// controller state encoding, InfiniBand RC opcode constants, and a helper for
// modulo-2^24 PSN distance.
// No ports (package).
// -----------------------------------------------------------------------------
package roce_pkg;

  localparam int PSN_W = 24;
  typedef logic [PSN_W-1:0] psn_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RETX   = 2'd2,
    ST_ERROR  = 2'd3
  } tx_state_e;

  // RC opcodes as carried in the BTH opcode field.
  localparam logic [7:0] RC_SEND_FIRST        = 8'h00;
  localparam logic [7:0] RC_SEND_MIDDLE       = 8'h01;
  localparam logic [7:0] RC_SEND_LAST         = 8'h02;
  localparam logic [7:0] RC_SEND_ONLY         = 8'h04;
  localparam logic [7:0] RC_RDMA_WRITE_FIRST  = 8'h06;
  localparam logic [7:0] RC_RDMA_WRITE_MIDDLE = 8'h07;
  localparam logic [7:0] RC_RDMA_WRITE_LAST   = 8'h08;
  localparam logic [7:0] RC_RDMA_WRITE_ONLY   = 8'h0A;
  localparam logic [7:0] RC_ACKNOWLEDGE       = 8'h11;

  // Forward distance from 'from' to 'to' in PSN space; the 24-bit result
  // wraps naturally across 0xFFFFFF -> 0x000000.
  function automatic psn_t psn_dist(input psn_t to, input psn_t from);
    return to - from;
  endfunction

endpackage

// File: rtl/roce_ack_timer.sv
// -----------------------------------------------------------------------------
// roce_ack_timer
// Counts cycles without ACK progress. Saturates at TIMEOUT and reports expiry
// while enabled. Only instantiated when ROCE_TX_ACK_TIMEOUT_EN is defined.
// Ports:
//   clk       in  clock
//   rst       in  synchronous active-high reset
//   clear_i   in  restart the count from zero (wins over enable_i)
//   enable_i  in  count this cycle
//   expire_o  out count has reached TIMEOUT while enabled
// -----------------------------------------------------------------------------
module roce_ack_timer #(
  parameter logic [31:0] TIMEOUT = 32'd65536
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  logic [31:0] timer_q;

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      timer_q <= '0;
    end else if (enable_i && (timer_q != TIMEOUT)) begin
      timer_q <= timer_q + 32'd1;
    end
  end

  assign expire_o = enable_i && (timer_q == TIMEOUT);

endmodule

// File: rtl/roce_tx_window_ctrl.sv
// -----------------------------------------------------------------------------
// roce_tx_window_ctrl
// RoCE RC transmit window controller. Tracks PSNs in flight between the next
// PSN to send and the oldest unacknowledged PSN, throttles the upstream packet
// generator to WINDOW outstanding PSNs, consumes cumulative ACKs, and requests
// go-back-N retransmission on NAK (and, with ROCE_TX_ACK_TIMEOUT_EN defined,
// on ACK timeout). Exceeding RETRY_MAX retransmits parks in a sticky error.
//
// Optional feature macro: ROCE_TX_ACK_TIMEOUT_EN (ACK timeout retransmit).
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   start, start_psn, abort           begin transfer at start_psn / cancel
//   tx_sent, tx_sent_psn, tx_sent_last  upstream issued a packet
//   ack_valid, ack_psn                cumulative ACK
//   nack_valid, nack_psn              NAK (restart from nack_psn)
//   tx_enable                         upstream may issue a packet
//   retx_valid, retx_ready, retx_psn  retransmit request handshake
//   done                              one-cycle transfer complete pulse
//   retry_err                         sticky retry-limit error
//   busy                              controller not idle
// -----------------------------------------------------------------------------
module roce_tx_window_ctrl
  import roce_pkg::*;
#(
  parameter int unsigned WINDOW      = 64,
  parameter logic [31:0] ACK_TIMEOUT = 32'd65536,
  parameter int unsigned RETRY_MAX   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PSN_W-1:0] start_psn,
  input  logic             abort,
  input  logic             tx_sent,
  input  logic [PSN_W-1:0] tx_sent_psn,
  input  logic             tx_sent_last,
  input  logic             ack_valid,
  input  logic [PSN_W-1:0] ack_psn,
  input  logic             nack_valid,
  input  logic [PSN_W-1:0] nack_psn,
  output logic             tx_enable,
  output logic             retx_valid,
  input  logic             retx_ready,
  output logic [PSN_W-1:0] retx_psn,
  output logic             done,
  output logic             retry_err,
  output logic             busy
);

  localparam int unsigned RCNT_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [RCNT_W-1:0] RETRY_LIM  = RCNT_W'(RETRY_MAX);
  localparam logic [PSN_W:0]    WINDOW_LIM = (PSN_W + 1)'(WINDOW);
  localparam psn_t              PSN_ONE    = psn_t'(1);

  tx_state_e         state_q;
  psn_t              next_psn_q;
  psn_t              acked_psn_q, acked_psn_d;
  psn_t              final_psn_q;
  logic              final_seen_q;
  logic [RCNT_W-1:0] retry_cnt_q, retry_cnt_d;
  psn_t              retx_psn_q;
  logic              done_q;

  psn_t outstanding;
  psn_t ack_dist;
  logic ack_acc;
  logic ack_done;
  logic timeout_hit;

  // NOTE: every signal below is assigned on every pass through the block, so
  // no path can leave a value held and infer a latch.
  always_comb begin
    outstanding = psn_dist(next_psn_q, acked_psn_q);
    ack_dist    = psn_dist(ack_psn, acked_psn_q);
    // An ACK is new only if it lands inside the in-flight span; anything at or
    // beyond the span (in wrapped distance) is stale or a duplicate.
    ack_acc     = ack_valid && ((state_q == ST_ACTIVE) || (state_q == ST_RETX))
                  && (ack_dist < outstanding);
    ack_done    = ack_acc && final_seen_q && (ack_psn == final_psn_q);
    acked_psn_d = ack_acc ? (ack_psn + PSN_ONE) : acked_psn_q;
    retry_cnt_d = ack_acc ? '0 : retry_cnt_q;
  end

`ifdef ROCE_TX_ACK_TIMEOUT_EN
  logic timer_clear;
  logic timer_en;
  logic timer_expire;

  assign timer_clear = (state_q != ST_ACTIVE) || ack_acc;
  assign timer_en    = (state_q == ST_ACTIVE) && (outstanding != '0);

  roce_ack_timer #(
    .TIMEOUT (ACK_TIMEOUT)
  ) u_ack_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (timer_clear),
    .enable_i (timer_en),
    .expire_o (timer_expire)
  );

  // ACK progress in the same cycle supersedes an expiring timer.
  assign timeout_hit = timer_expire && !ack_acc;
`else
  logic unused_ack_timeout;
  assign unused_ack_timeout = ^ACK_TIMEOUT;
  assign timeout_hit        = 1'b0;
`endif

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      next_psn_q   <= '0;
      acked_psn_q  <= '0;
      final_psn_q  <= '0;
      final_seen_q <= 1'b0;
      retry_cnt_q  <= '0;
      retx_psn_q   <= '0;
      done_q       <= 1'b0;
    end else if (abort) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      acked_psn_q <= acked_psn_d;
      retry_cnt_q <= retry_cnt_d;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            next_psn_q   <= start_psn;
            acked_psn_q  <= start_psn;
            final_seen_q <= 1'b0;
            retry_cnt_q  <= '0;
            state_q      <= ST_ACTIVE;
          end
        end

        ST_ACTIVE: begin
          if (tx_sent) begin
            next_psn_q <= tx_sent_psn + PSN_ONE;
            if (tx_sent_last) begin
              final_psn_q  <= tx_sent_psn;
              final_seen_q <= 1'b1;
            end
          end
          // The ACK is applied before the NAK, so an ACK arriving with a NAK
          // resets the retry budget the NAK is then judged against.
          if (ack_done) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else if (nack_valid) begin
            if (retry_cnt_d == RETRY_LIM) begin
              state_q <= ST_ERROR;
            end else begin
              retx_psn_q <= nack_psn;
              state_q    <= ST_RETX;
            end
          end else if (timeout_hit) begin
            if (retry_cnt_q == RETRY_LIM) begin
              state_q <= ST_ERROR;
            end else begin
              retx_psn_q <= acked_psn_q;
              state_q    <= ST_RETX;
            end
          end
        end

        ST_RETX: begin
          if (ack_done) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else if (retx_ready) begin
            // Go-back-N: resume issuing from the restart PSN; the final packet
            // will be sent again, so its marker is rearmed by the upstream.
            next_psn_q   <= retx_psn_q;
            retry_cnt_q  <= retry_cnt_d + 1'b1;
            final_seen_q <= 1'b0;
            state_q      <= ST_ACTIVE;
          end
        end

        ST_ERROR: begin
          state_q <= ST_ERROR;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_enable  = (state_q == ST_ACTIVE) && ({1'b0, outstanding} < WINDOW_LIM)
                      && !final_seen_q;
  assign retx_valid = (state_q == ST_RETX);
  assign retx_psn   = retx_psn_q;
  assign done       = done_q;
  assign retry_err  = (state_q == ST_ERROR);
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_roce_tx_window_ctrl.sv
// -----------------------------------------------------------------------------
// tb_roce_tx_window_ctrl
// Self-checking bench for roce_tx_window_ctrl (WINDOW=4, RETRY_MAX=2,
// ACK_TIMEOUT=100). A table of {inputs, expected outputs} rows is applied one
// clock per row; expectations go through a scoreboard queue and are compared
// one time unit after the edge. An ACK-timeout sequence follows, whose
// expectation depends on ROCE_TX_ACK_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_roce_tx_window_ctrl;
  import roce_pkg::*;

  localparam logic [7:0] OP_NONE = 8'h00;
  localparam logic [7:0] OP_RST  = 8'h01;
  localparam logic [7:0] OP_STA  = 8'h02;
  localparam logic [7:0] OP_ABT  = 8'h04;
  localparam logic [7:0] OP_SNT  = 8'h08;
  localparam logic [7:0] OP_LST  = 8'h10;
  localparam logic [7:0] OP_ACK  = 8'h20;
  localparam logic [7:0] OP_NAK  = 8'h40;
  localparam logic [7:0] OP_RDY  = 8'h80;

  typedef struct packed {
    logic        tx_enable;
    logic        retx_valid;
    logic [23:0] retx_psn;
    logic        done;
    logic        retry_err;
    logic        busy;
  } out_t;

  typedef struct packed {
    logic [7:0]  ops;
    logic [23:0] p_sent;   // also the start PSN
    logic [23:0] p_ack;
    logic [23:0] p_nack;
    out_t        exp;
  } vec_t;

  typedef struct packed {
    out_t exp;
    logic cmp_psn;
  } sb_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [23:0] start_psn;
  logic        abort;
  logic        tx_sent;
  logic [23:0] tx_sent_psn;
  logic        tx_sent_last;
  logic        ack_valid;
  logic [23:0] ack_psn;
  logic        nack_valid;
  logic [23:0] nack_psn;
  logic        tx_enable;
  logic        retx_valid;
  logic        retx_ready;
  logic [23:0] retx_psn;
  logic        done;
  logic        retry_err;
  logic        busy;

  int    n_vec = 0;
  int    n_err = 0;
  vec_t  tbl[$];
  string tbl_name[$];
  sb_t   sb_q[$];

  roce_tx_window_ctrl #(
    .WINDOW      (4),
    .ACK_TIMEOUT (32'd100),
    .RETRY_MAX   (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .start_psn    (start_psn),
    .abort        (abort),
    .tx_sent      (tx_sent),
    .tx_sent_psn  (tx_sent_psn),
    .tx_sent_last (tx_sent_last),
    .ack_valid    (ack_valid),
    .ack_psn      (ack_psn),
    .nack_valid   (nack_valid),
    .nack_psn     (nack_psn),
    .tx_enable    (tx_enable),
    .retx_valid   (retx_valid),
    .retx_ready   (retx_ready),
    .retx_psn     (retx_psn),
    .done         (done),
    .retry_err    (retry_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  function automatic out_t o(input logic te, input logic rv, input logic [23:0] p,
                             input logic dn, input logic er, input logic bz);
    out_t r;
    r.tx_enable  = te;
    r.retx_valid = rv;
    r.retx_psn   = p;
    r.done       = dn;
    r.retry_err  = er;
    r.busy       = bz;
    return r;
  endfunction

  function automatic out_t cur_out();
    return o(tx_enable, retx_valid, retx_psn, done, retry_err, busy);
  endfunction

  task automatic add(input string n, input logic [7:0] ops, input logic [23:0] ps,
                     input logic [23:0] pa, input logic [23:0] pn, input out_t e);
    vec_t v;
    v.ops    = ops;
    v.p_sent = ps;
    v.p_ack  = pa;
    v.p_nack = pn;
    v.exp    = e;
    tbl.push_back(v);
    tbl_name.push_back(n);
  endtask

  // retx_psn is only compared while a retransmit is requested or after reset;
  // otherwise it is don't-care.
  task automatic check(input string name, input out_t act, input out_t exp,
                       input logic cmp_psn);
    out_t a;
    out_t e;
    a = act;
    e = exp;
    if (!cmp_psn) begin
      a.retx_psn = '0;
      e.retx_psn = '0;
    end
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got te=%b rv=%b psn=%h done=%b err=%b busy=%b, want te=%b rv=%b psn=%h done=%b err=%b busy=%b",
               name, act.tx_enable, act.retx_valid, act.retx_psn, act.done, act.retry_err,
               act.busy, exp.tx_enable, exp.retx_valid, exp.retx_psn, exp.done,
               exp.retry_err, exp.busy);
    end
  endtask

  task automatic idle_inputs();
    rst          = 1'b0;
    start        = 1'b0;
    start_psn    = '0;
    abort        = 1'b0;
    tx_sent      = 1'b0;
    tx_sent_psn  = '0;
    tx_sent_last = 1'b0;
    ack_valid    = 1'b0;
    ack_psn      = '0;
    nack_valid   = 1'b0;
    nack_psn     = '0;
    retx_ready   = 1'b0;
  endtask

  task automatic apply(input string name, input vec_t v);
    sb_t s;
    rst          = v.ops[0];
    start        = v.ops[1];
    start_psn    = v.p_sent;
    abort        = v.ops[2];
    tx_sent      = v.ops[3];
    tx_sent_psn  = v.p_sent;
    tx_sent_last = v.ops[4];
    ack_valid    = v.ops[5];
    ack_psn      = v.p_ack;
    nack_valid   = v.ops[6];
    nack_psn     = v.p_nack;
    retx_ready   = v.ops[7];
    s.exp        = v.exp;
    s.cmp_psn    = v.ops[0] || v.exp.retx_valid;
    sb_q.push_back(s);
    @(posedge clk);
    #1;
    s = sb_q.pop_front();
    check(name, cur_out(), s.exp, s.cmp_psn);
    idle_inputs();
  endtask

  initial begin
    vec_t v;
    int   cyc;
    logic seen;

    idle_inputs();

    // Reset and idle behaviour.
    add("reset",       OP_RST,                 0, 0, 0, o(0,0,24'h0,0,0,0));
    add("idle_ignore", OP_SNT|OP_ACK|OP_NAK,   5, 5, 5, o(0,0,24'h0,0,0,0));
    // Window stall at WINDOW=4, reopened by a cumulative ACK.
    add("start_10",    OP_STA,           24'h10, 0, 0, o(1,0,0,0,0,1));
    add("send_10",     OP_SNT,           24'h10, 0, 0, o(1,0,0,0,0,1));
    add("send_11",     OP_SNT,           24'h11, 0, 0, o(1,0,0,0,0,1));
    add("send_12",     OP_SNT,           24'h12, 0, 0, o(1,0,0,0,0,1));
    add("send_13",     OP_SNT,           24'h13, 0, 0, o(0,0,0,0,0,1));
    add("start_busy",  OP_STA,           24'h99, 0, 0, o(0,0,0,0,0,1));
    add("ack_11",      OP_ACK,           0, 24'h11, 0, o(1,0,0,0,0,1));
    add("ack_dup_11",  OP_ACK,           0, 24'h11, 0, o(1,0,0,0,0,1));
    add("abort_a",     OP_ABT,           0, 0, 0,      o(0,0,0,0,0,0));
    // PSN wrap with completion on ACK of 0x000000.
    add("start_fffffe", OP_STA,          24'hFFFFFE, 0, 0, o(1,0,0,0,0,1));
    add("send_fffffe",  OP_SNT,          24'hFFFFFE, 0, 0, o(1,0,0,0,0,1));
    add("send_ffffff",  OP_SNT,          24'hFFFFFF, 0, 0, o(1,0,0,0,0,1));
    add("send_last_0",  OP_SNT|OP_LST,   24'h000000, 0, 0, o(0,0,0,0,0,1));
    add("ack_wrap_0",   OP_ACK,          0, 24'h000000, 0, o(0,0,0,1,0,0));
    add("done_pulse",   OP_NONE,         0, 0, 0,          o(0,0,0,0,0,0));
    // Stale ACK and same-cycle tx_sent + ACK.
    add("start_50",     OP_STA,          24'h50, 0, 0, o(1,0,0,0,0,1));
    add("send_50",      OP_SNT,          24'h50, 0, 0, o(1,0,0,0,0,1));
    add("ack_stale_30", OP_ACK,          0, 24'h30, 0, o(1,0,0,0,0,1));
    add("sent_and_ack", OP_SNT|OP_ACK,   24'h51, 24'h50, 0, o(1,0,0,0,0,1));
    add("send_52",      OP_SNT,          24'h52, 0, 0, o(1,0,0,0,0,1));
    add("send_53",      OP_SNT,          24'h53, 0, 0, o(1,0,0,0,0,1));
    add("send_54",      OP_SNT,          24'h54, 0, 0, o(0,0,0,0,0,1));
    add("ack_53",       OP_ACK,          0, 24'h53, 0, o(1,0,0,0,0,1));
    add("abort_b",      OP_ABT,          0, 0, 0,      o(0,0,0,0,0,0));
    // NAK with held retransmit request, then the retry limit (RETRY_MAX=2).
    // The controller does not police tx_sent, so 8 PSNs go out past the window.
    add("start_20",     OP_STA,          24'h20, 0, 0, o(1,0,0,0,0,1));
    add("send_20",      OP_SNT,          24'h20, 0, 0, o(1,0,0,0,0,1));
    add("send_21",      OP_SNT,          24'h21, 0, 0, o(1,0,0,0,0,1));
    add("send_22",      OP_SNT,          24'h22, 0, 0, o(1,0,0,0,0,1));
    add("send_23",      OP_SNT,          24'h23, 0, 0, o(0,0,0,0,0,1));
    add("send_24",      OP_SNT,          24'h24, 0, 0, o(0,0,0,0,0,1));
    add("send_25",      OP_SNT,          24'h25, 0, 0, o(0,0,0,0,0,1));
    add("send_26",      OP_SNT,          24'h26, 0, 0, o(0,0,0,0,0,1));
    add("send_27",      OP_SNT,          24'h27, 0, 0, o(0,0,0,0,0,1));
    add("nack_23",      OP_NAK,          0, 0, 24'h23, o(0,1,24'h23,0,0,1));
    add("retx_hold_1",  OP_NONE,         0, 0, 0,      o(0,1,24'h23,0,0,1));
    add("retx_hold_2",  OP_NAK|OP_SNT,   24'h30, 0, 24'h25, o(0,1,24'h23,0,0,1));
    add("retx_hold_3",  OP_NONE,         0, 0, 0,      o(0,1,24'h23,0,0,1));
    add("retx_hs_23",   OP_RDY,          0, 0, 0,      o(1,0,24'h23,0,0,1));
    add("resend_23",    OP_SNT,          24'h23, 0, 0, o(0,0,0,0,0,1));
    add("nack_20",      OP_NAK,          0, 0, 24'h20, o(0,1,24'h20,0,0,1));
    add("retx_hs_20",   OP_RDY,          0, 0, 0,      o(1,0,24'h20,0,0,1));
    add("nack_limit",   OP_NAK,          0, 0, 24'h21, o(0,0,0,0,1,1));
    add("err_sticky",   OP_SNT|OP_ACK|OP_NAK, 24'h21, 24'h21, 24'h21, o(0,0,0,0,1,1));
    add("abort_err",    OP_ABT,          0, 0, 0,      o(0,0,0,0,0,0));
    // Same-cycle ACK + NAK: the ACK clears the retry count before the NAK.
    add("start_60",     OP_STA,          24'h60, 0, 0, o(1,0,0,0,0,1));
    add("send_60",      OP_SNT,          24'h60, 0, 0, o(1,0,0,0,0,1));
    add("send_61",      OP_SNT,          24'h61, 0, 0, o(1,0,0,0,0,1));
    add("nack_60",      OP_NAK,          0, 0, 24'h60, o(0,1,24'h60,0,0,1));
    add("retx_hs_60",   OP_RDY,          0, 0, 0,      o(1,0,24'h60,0,0,1));
    add("resend_60",    OP_SNT,          24'h60, 0, 0, o(1,0,0,0,0,1));
    add("resend_61",    OP_SNT,          24'h61, 0, 0, o(1,0,0,0,0,1));
    add("nack_61",      OP_NAK,          0, 0, 24'h61, o(0,1,24'h61,0,0,1));
    add("retx_hs_61",   OP_RDY,          0, 0, 0,      o(1,0,24'h61,0,0,1));
    add("ack_nack_same", OP_ACK|OP_NAK,  0, 24'h60, 24'h61, o(0,1,24'h61,0,0,1));
    add("retx_hs_61b",  OP_RDY,          0, 0, 0,      o(1,0,24'h61,0,0,1));
    // Reset in the middle of a retransmit request.
    add("resend_61b",   OP_SNT,          24'h61, 0, 0, o(1,0,0,0,0,1));
    add("nack_61b",     OP_NAK,          0, 0, 24'h61, o(0,1,24'h61,0,0,1));
    add("rst_mid_retx", OP_RST,          0, 0, 0,      o(0,0,24'h0,0,0,0));
    add("after_rst",    OP_NONE,         0, 0, 0,      o(0,0,0,0,0,0));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl_name[i], tbl[i]);
    end

    // ACK timeout: one packet 0x40 left unacknowledged.
    v = '0;
    v.ops = OP_STA; v.p_sent = 24'h40; v.exp = o(1,0,0,0,0,1);
    apply("to_start_40", v);
    v.ops = OP_SNT; v.p_sent = 24'h40; v.exp = o(1,0,0,0,0,1);
    apply("to_send_40", v);
    cyc  = 0;
    seen = 1'b0;
    for (int i = 0; i < 150 && !seen; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (retx_valid) seen = 1'b1;
    end
`ifdef ROCE_TX_ACK_TIMEOUT_EN
    n_vec++;
    if (!seen || cyc < 100 || cyc > 102) begin
      n_err++;
      $display("FAIL timeout_latency: got retx after %0d cycles (seen=%b), want 100..102",
               cyc, seen);
    end
    n_vec++;
    if (retx_psn !== 24'h40) begin
      n_err++;
      $display("FAIL timeout_psn: got %h, want 000040", retx_psn);
    end
`else
    n_vec++;
    if (seen) begin
      n_err++;
      $display("FAIL no_timeout: got retx_valid after %0d cycles, want none in 150", cyc);
    end
`endif
    v.ops = OP_ABT; v.p_sent = 0; v.exp = o(0,0,0,0,0,0);
    apply("to_abort", v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/roce_tx_window_ctrl.md
ROCE_TX_WINDOW_CTRL -- requirements
Module: roce_tx_window_ctrl

Interface
REQ-001 SHALL have parameter WINDOW, default 64, max unacknowledged PSNs in flight (1..2^23).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 32'd65536, clk cycles without ACK progress before retransmit.
REQ-003 SHALL have parameter RETRY_MAX, default 7, retransmits allowed per transfer before error.
REQ-004 SHALL have port clk  in  1  sole clock; rst  in  1  synchronous active-high reset.
REQ-005 SHALL have ports start  in  1  start pulse; start_psn  in  24  first PSN; abort  in  1  cancel transfer.
REQ-006 SHALL have ports tx_sent  in  1  packet issued pulse; tx_sent_psn  in  24  its PSN; tx_sent_last  in  1  final packet of transfer.
REQ-007 SHALL have ports ack_valid  in  1; ack_psn  in  24  cumulative ACK PSN; nack_valid  in  1; nack_psn  in  24.
REQ-008 SHALL have ports tx_enable  out  1  upstream may issue; retx_valid  out  1; retx_ready  in  1; retx_psn  out  24  restart PSN.
REQ-009 SHALL have ports done  out  1  transfer complete pulse; retry_err  out  1  sticky error; busy  out  1  state != IDLE.

Function
REQ-010 SHALL implement states IDLE, ACTIVE, RETX, ERROR.
REQ-011 SHALL hold registers next_psn, acked_psn (oldest unacked), final_psn, final_seen, retry_cnt, timer.
REQ-012 SHALL, in IDLE on start, load next_psn=acked_psn=start_psn, clear final_seen/retry_cnt/timer, enter ACTIVE next cycle; start ignored outside IDLE.
REQ-013 SHALL compute outstanding = (next_psn - acked_psn) mod 2^24 (24-bit wrap subtraction).
REQ-014 SHALL drive tx_enable = (state==ACTIVE) && outstanding < WINDOW && !final_seen, combinational from registers only.
REQ-015 SHALL, on tx_sent in ACTIVE, set next_psn = tx_sent_psn+1 mod 2^24; with tx_sent_last also set final_psn=tx_sent_psn, final_seen=1.
REQ-016 SHALL accept ack when d=(ack_psn-acked_psn) mod 2^24 < outstanding: acked_psn=ack_psn+1, timer=0, retry_cnt=0; otherwise ignore as stale/duplicate.
REQ-017 SHALL, when final_seen and an accepted ack has ack_psn==final_psn, pulse done one cycle and return to IDLE; PSN wrap 0xFFFFFF->0x000000 handled identically.
REQ-018 SHALL, on nack_valid in ACTIVE, set retx_psn=nack_psn and enter RETX; if retry_cnt==RETRY_MAX enter ERROR instead.
REQ-019 SHALL hold retx_valid=1 and retx_psn stable in RETX until retx_ready; on handshake set next_psn=retx_psn, retry_cnt+1, timer=0, clear final_seen, return to ACTIVE.
REQ-020 SHALL, same-cycle ack and nack: apply ack first, then nack; same-cycle tx_sent and ack: apply both.
REQ-021 SHALL ignore tx_sent, ack, nack in IDLE and ERROR; in RETX accept ack but ignore tx_sent and nack.
REQ-022 SHALL, in ERROR, hold retry_err=1, tx_enable=0 until abort or rst.
REQ-023 SHALL, on abort in any state, enter IDLE next cycle, clear retx_valid and retry_err; rst has priority over abort.

Reset
REQ-024 SHALL on rst set state IDLE, tx_enable 0, retx_valid 0, retx_psn 0, done 0, retry_err 0, busy 0, all internal counters/PSNs 0.
REQ-025 SHALL, with rst mid-transfer (any state), discard all context; no done pulse.

Configuration
REQ-026 SHALL, with ROCE_TX_ACK_TIMEOUT_EN defined, increment timer each cycle in ACTIVE while outstanding>0; at timer==ACK_TIMEOUT set retx_psn=acked_psn and enter RETX (or ERROR if retry_cnt==RETRY_MAX).
REQ-027 SHALL, without ROCE_TX_ACK_TIMEOUT_EN, omit timer logic entirely; retransmit only on NAK; ACK_TIMEOUT unused.

Structure
REQ-028 SHALL take PSN width (24), state encoding and RC opcode constants from shared package roce_pkg.
REQ-029 SHALL isolate timeout counter in sub-module roce_ack_timer (clear, enable, expire), instantiated only under ROCE_TX_ACK_TIMEOUT_EN.

Verification
REQ-030 SHALL cover window stall: WINDOW=4, start_psn=0x10, send 0x10..0x13 -> tx_enable=0; ack_psn=0x11 -> tx_enable=1 next cycle.
REQ-031 SHALL cover wrap: start_psn=0xFFFFFE, send 0xFFFFFE,0xFFFFFF,0x000000(last), ack_psn=0x000000 -> done pulse, IDLE.
REQ-032 SHALL cover NAK: in flight 0x20..0x27, nack_psn=0x23 -> retx_valid, retx_psn=0x23, held 3 cycles with retx_ready=0, then next_psn=0x23.
REQ-033 SHALL cover retry limit: RETRY_MAX=2, three NAKs without ACK -> retry_err=1, tx_enable=0; abort -> IDLE, retry_err=0.
REQ-034 SHALL cover timeout (macro on): ACK_TIMEOUT=100, one packet 0x40 unacked -> retx_psn=0x40 at cycle 100; macro off -> no retx.
REQ-035 SHALL cover stale ack: acked_psn=0x50, ack_psn=0x30 -> no state change; rst mid-RETX -> all outputs reset values.
